// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory request-ready handshake between the sequencer and the memories.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// single-cycle writeback strobes, retire counter and a sticky trap on fault.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter logic [31:0] INSTRET_RST = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_ctrl_if.master         bus,
    output logic                      ir_we,
    input  logic                      R,
    input  logic                      I_L,
    input  logic                      I_C,
    input  logic                      JALR,
    input  logic                      S,
    input  logic                      B,
    input  logic                      LUI,
    input  logic                      AUIPC,
    input  logic                      JAL,
    input  logic                      PCSel_temp,
    input  logic                      RegWEn_temp,
    input  logic                      MemRW_temp,
    input  logic [1:0]                WBSel_temp,
    output logic                      reg_we,
    output logic [1:0]                wb_sel,
    output logic                      pc_we,
    output logic                      pc_sel,
    output logic [2:0]                state,
    output logic                      trap,
    output logic [31:0]               instret
);

    localparam int unsigned WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT > 0);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [31:0]         instret_q, instret_d;

    logic                imem_req_c;
    logic                dmem_req_c;
    logic                dmem_we_c;
    logic [8:0]          class_flags;
    logic                class_ok;

    assign class_flags = {R, I_L, I_C, JALR, S, B, LUI, AUIPC, JAL};
    assign class_ok    = ($countones(class_flags) == 1);

    // Next-state, wait counter, retire count and combinational strobes.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instret_d  = instret_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        wb_sel     = 2'b00;

        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_we      = 1'b1;
                    state_d    = S_DECODE;
                    wait_cnt_d = '0;
                end else if (TIMEOUT_EN) begin
                    if (wait_cnt_q == WAIT_MAX) state_d = S_TRAP;
                    else                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DECODE: state_d = class_ok ? S_EXEC : S_TRAP;
            S_EXEC:   state_d = (I_L || S) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = MemRW_temp;
                if (bus.dmem_ready) begin
                    state_d    = S_WB;
                    wait_cnt_d = '0;
                end else if (TIMEOUT_EN) begin
                    if (wait_cnt_q == WAIT_MAX) state_d = S_TRAP;
                    else                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we    = RegWEn_temp;
                wb_sel    = WBSel_temp;
                pc_we     = 1'b1;
                pc_sel    = PCSel_temp;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // Reset suppresses every strobe so an aborted instruction leaves no side effect.
        if (rst) begin
            imem_req_c = 1'b0;
            dmem_req_c = 1'b0;
            dmem_we_c  = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            pc_we      = 1'b0;
            pc_sel     = 1'b0;
            wb_sel     = 2'b00;
        end
    end

    // State, wait counter and retire counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            instret_q  <= INSTRET_RST;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instret_q  <= instret_d;
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.dmem_req = dmem_req_c;
    assign bus.dmem_we  = dmem_we_c;
    assign state        = state_q;
    assign trap         = (state_q == S_TRAP);
    assign instret      = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + randomized bench for multicycle_ctrl driven from a per-cycle expected trace.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        R, I_L, I_C, JALR, S, B, LUI, AUIPC, JAL;
    logic        PCSel_temp, RegWEn_temp, MemRW_temp;
    logic [1:0]  WBSel_temp;

    logic        ir_we, reg_we, pc_we, pc_sel, trap;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic [31:0] instret;

    logic        w_ir_we, w_reg_we, w_pc_we, w_pc_sel, w_trap;
    logic [1:0]  w_wb_sel;
    logic [2:0]  w_state;
    logic [31:0] w_instret;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus_w ();
    assign bus_w.imem_ready = bus.imem_ready;
    assign bus_w.dmem_ready = bus.dmem_ready;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ir_we(ir_we),
        .R(R), .I_L(I_L), .I_C(I_C), .JALR(JALR), .S(S), .B(B), .LUI(LUI), .AUIPC(AUIPC), .JAL(JAL),
        .PCSel_temp(PCSel_temp), .RegWEn_temp(RegWEn_temp), .MemRW_temp(MemRW_temp), .WBSel_temp(WBSel_temp),
        .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .state(state), .trap(trap), .instret(instret)
    );

    // Second copy starting its retire count at all-ones to exercise the wrap to zero.
    multicycle_ctrl #(.MEM_TIMEOUT(15), .INSTRET_RST(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .rst(rst), .bus(bus_w), .ir_we(w_ir_we),
        .R(R), .I_L(I_L), .I_C(I_C), .JALR(JALR), .S(S), .B(B), .LUI(LUI), .AUIPC(AUIPC), .JAL(JAL),
        .PCSel_temp(PCSel_temp), .RegWEn_temp(RegWEn_temp), .MemRW_temp(MemRW_temp), .WBSel_temp(WBSel_temp),
        .reg_we(w_reg_we), .wb_sel(w_wb_sel), .pc_we(w_pc_we), .pc_sel(w_pc_sel),
        .state(w_state), .trap(w_trap), .instret(w_instret)
    );

    typedef struct {
        logic        rst, imr, dmr;
        logic [8:0]  flags;
        logic        pcs_t, rwe_t, mrw_t;
        logic [1:0]  wbs_t;
        logic [2:0]  st;
        logic        imreq, irwe, dmreq, dmwe, regwe, pcwe, pcsel;
        logic [1:0]  wbsel;
        logic        trp;
        logic [31:0] ir;
    } cyc_t;

    cyc_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;

    logic [8:0]  cur_flags;
    logic        cur_pcs, cur_rwe, cur_mrw;
    logic [1:0]  cur_wbs;
    logic [31:0] exp_instret;

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic check(input string tag, input logic [44:0] obs, input logic [44:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic push(input logic rst_i, input logic imr, input logic dmr, input logic [2:0] st,
                        input logic imreq, input logic irwe, input logic dmreq, input logic dmwe,
                        input logic regwe, input logic pcwe, input logic pcsel,
                        input logic [1:0] wbsel, input logic trp);
        cyc_t c;
        c.rst = rst_i; c.imr = imr; c.dmr = dmr;
        c.flags = cur_flags; c.pcs_t = cur_pcs; c.rwe_t = cur_rwe; c.mrw_t = cur_mrw; c.wbs_t = cur_wbs;
        c.st = st; c.imreq = imreq; c.irwe = irwe; c.dmreq = dmreq; c.dmwe = dmwe;
        c.regwe = regwe; c.pcwe = pcwe; c.pcsel = pcsel; c.wbsel = wbsel; c.trp = trp;
        c.ir = exp_instret;
        q.push_back(c);
    endtask

    task automatic set_ctx(input logic [8:0] fl, input logic pcs, input logic rwe,
                           input logic mrw, input logic [1:0] wbs);
        cur_flags = fl; cur_pcs = pcs; cur_rwe = rwe; cur_mrw = mrw; cur_wbs = wbs;
    endtask

    // Fetch (fw waits), decode, execute, optional memory phase (mw waits), writeback.
    task automatic emit_instr(input logic [8:0] fl, input logic pcs, input logic rwe, input logic mrw,
                              input logic [1:0] wbs, input int fw, input int mw);
        set_ctx(fl, pcs, rwe, mrw, wbs);
        for (int i = 0; i < fw; i++) push(0, 0, rb(), 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, 1, rb(), 3'd0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        if (fl[7] || fl[4]) begin
            for (int i = 0; i < mw; i++) push(0, rb(), 0, 3'd3, 0, 0, 1, mrw, 0, 0, 0, 2'b00, 0);
            push(0, rb(), 1, 3'd3, 0, 0, 1, mrw, 0, 0, 0, 2'b00, 0);
        end
        push(0, rb(), rb(), 3'd4, 0, 0, 0, 0, rwe, 1, pcs, wbs, 0);
        exp_instret = exp_instret + 32'd1;
    endtask

    // A few cycles parked in TRAP, then a reset cycle that returns to FETCH.
    task automatic emit_trap_tail(input int n);
        for (int i = 0; i < n; i++) push(0, rb(), rb(), 3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        push(1, rb(), rb(), 3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
        exp_instret = 32'd0;
    endtask

    task automatic emit_illegal(input logic [8:0] fl);
        set_ctx(fl, rb(), rb(), rb(), 2'($urandom_range(3, 0)));
        push(0, 1, rb(), 3'd0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        emit_trap_tail(3);
    endtask

    task automatic emit_fetch_timeout();
        set_ctx(9'b1_0000_0000, 0, 1, 0, 2'b01);
        for (int i = 0; i < 16; i++) push(0, 0, rb(), 3'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        emit_trap_tail(4);
    endtask

    task automatic emit_mem_timeout(input logic [8:0] fl, input logic mrw);
        set_ctx(fl, 0, ~mrw, mrw, 2'b00);
        push(0, 1, rb(), 3'd0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 16; i++) push(0, rb(), 0, 3'd3, 0, 0, 1, mrw, 0, 0, 0, 2'b00, 0);
        emit_trap_tail(2);
    endtask

    // Load aborted by reset while waiting in MEM: no writeback and no retire.
    task automatic emit_rst_in_mem();
        set_ctx(9'b0_1000_0000, 0, 1, 0, 2'b00);
        push(0, 1, rb(), 3'd0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), rb(), 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), 0, 3'd3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        push(0, rb(), 0, 3'd3, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        push(1, rb(), rb(), 3'd3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        exp_instret = 32'd0;
    endtask

    task automatic run_q();
        cyc_t        c;
        logic [44:0] obs, exp;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst = c.rst;
            bus.imem_ready = c.imr;
            bus.dmem_ready = c.dmr;
            {R, I_L, I_C, JALR, S, B, LUI, AUIPC, JAL} = c.flags;
            PCSel_temp = c.pcs_t; RegWEn_temp = c.rwe_t; MemRW_temp = c.mrw_t; WBSel_temp = c.wbs_t;
            #1;
            exp = {c.st, c.imreq, c.irwe, c.dmreq, c.dmwe, c.regwe, c.pcwe, c.pcsel, c.wbsel, c.trp, c.ir};
            obs = {state, bus.imem_req, ir_we, bus.dmem_req, bus.dmem_we, reg_we, pc_we, pc_sel,
                   wb_sel, trap, instret};
            check("main", obs, exp);
            exp = {c.st, c.imreq, c.irwe, c.dmreq, c.dmwe, c.regwe, c.pcwe, c.pcsel, c.wbsel, c.trp,
                   c.ir + 32'hFFFF_FFFF};
            obs = {w_state, bus_w.imem_req, w_ir_we, bus_w.dmem_req, bus_w.dmem_we, w_reg_we, w_pc_we,
                   w_pc_sel, w_wb_sel, w_trap, w_instret};
            check("wrap", obs, exp);
            cyc_n++;
        end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        {R, I_L, I_C, JALR, S, B, LUI, AUIPC, JAL} = 9'b0;
        PCSel_temp = 1'b0; RegWEn_temp = 1'b0; MemRW_temp = 1'b0; WBSel_temp = 2'b00;
        exp_instret = 32'd0;
        set_ctx(9'b0, 0, 0, 0, 2'b00);
        repeat (2) @(negedge clk);

        // Reset held: state FETCH, counter cleared, every strobe suppressed.
        push(1, 1, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        // ADD, LW with three data waits, SW, taken BEQ, JAL.
        emit_instr(9'b1_0000_0000, 0, 1, 0, 2'b01, 0, 0);
        emit_instr(9'b0_1000_0000, 0, 1, 0, 2'b00, 0, 3);
        emit_instr(9'b0_0001_0000, 0, 0, 1, 2'b00, 0, 0);
        emit_instr(9'b0_0000_1000, 1, 0, 0, 2'b01, 0, 0);
        emit_instr(9'b0_0000_0001, 1, 1, 0, 2'b10, 0, 0);
        // Ready on the last permitted cycle of fetch and of memory.
        emit_instr(9'b0_1000_0000, 0, 1, 0, 2'b00, 15, 15);
        run_q();

        emit_fetch_timeout();
        emit_illegal(9'b0);
        emit_illegal(9'b1_0100_0000);
        emit_mem_timeout(9'b0_0001_0000, 1);
        emit_rst_in_mem();
        emit_instr(9'b0_0000_0100, 0, 1, 0, 2'b01, 1, 0);
        run_q();

        for (int k = 0; k < 40; k++) begin
            int unsigned r;
            r = $urandom_range(10, 0);
            if (r == 9) begin
                int unsigned a, b2;
                logic [8:0]  fl;
                a  = $urandom_range(8, 0);
                b2 = (a + $urandom_range(8, 1)) % 9;
                fl = 9'b0;
                fl[a]  = 1'b1;
                fl[b2] = 1'b1;
                emit_illegal(fl);
            end else if (r == 10) begin
                emit_rst_in_mem();
            end else begin
                logic [8:0] fl;
                fl = 9'b1 << r;
                emit_instr(fl, rb(), rb(), rb(), 2'($urandom_range(2, 0)),
                           int'($urandom_range(4, 0)), int'($urandom_range(4, 0)));
            end
            run_q();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
